// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared widths, state enum and final-byte index for packet_serializer (SERIALIZER_CHECKSUM_EN)
package pkt_pkg;

    localparam int PKT_W         = 32;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_PKT = 4;
    localparam int CNT_W         = 16;
    localparam int IDX_W         = 3;

`ifdef SERIALIZER_CHECKSUM_EN
    // The XOR byte rides after the data bytes, so the packet ends one index later.
    localparam int LAST_IDX = BYTES_PER_PKT;
`else
    localparam int LAST_IDX = BYTES_PER_PKT - 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage

// File: rtl/byte_sel.sv
// rtl/byte_sel.sv - picks the byte at an index from a packet word; XOR byte at the extra index with SERIALIZER_CHECKSUM_EN
module byte_sel
    import pkt_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic [PKT_W-1:0]  word,
    input  logic [IDX_W-1:0]  idx,
    output logic [BYTE_W-1:0] byte_out
);

    logic [IDX_W-1:0] lane;

    // Map the send index onto a byte lane of the word, then pick that lane.
    always_comb begin
        lane     = MSB_FIRST ? (IDX_W'(BYTES_PER_PKT - 1) - idx) : idx;
        byte_out = word[lane*BYTE_W +: BYTE_W];
`ifdef SERIALIZER_CHECKSUM_EN
        if (idx == IDX_W'(BYTES_PER_PKT)) begin
            byte_out = word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
        end
`endif
    end

endmodule

// File: rtl/packet_serializer.sv
// rtl/packet_serializer.sv - pops 32-bit words from a queue and streams them as bytes; SERIALIZER_CHECKSUM_EN adds an XOR byte
module packet_serializer
    import pkt_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              Clk_r,
    input  logic              Rst_n,
    input  logic [PKT_W-1:0]  Packet_In,
    input  logic              Empty,
    output logic              Read_Ack,
    output logic [BYTE_W-1:0] Byte_Out,
    output logic              Byte_Valid,
    input  logic              Byte_Ready,
    output logic              Byte_Last,
    output logic [CNT_W-1:0]  Pkt_Count
);

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic [PKT_W-1:0]  hold;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [BYTE_W-1:0] sel_byte;
    logic              is_last;
    logic              handshake;

    assign is_last   = (idx == IDX_W'(LAST_IDX));
    assign handshake = (state == SEND) && Byte_Ready;
    assign Pkt_Count = cnt;

    byte_sel #(
        .MSB_FIRST (MSB_FIRST)
    ) u_byte_sel (
        .word     (hold),
        .idx      (idx),
        .byte_out (sel_byte)
    );

    // State, captured word, byte index and packet counter; armed keeps the first fetch off the first edge after reset.
    always_ff @(posedge Clk_r or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            hold  <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (state == FETCH) begin
                hold <= Packet_In;
                idx  <= '0;
            end else if (handshake && !is_last) begin
                idx <= idx + 1'b1;
            end
            if (handshake && is_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Next state plus Moore outputs decoded from the registered state.
    always_comb begin
        state_nxt  = state;
        Read_Ack   = 1'b0;
        Byte_Valid = 1'b0;
        Byte_Last  = 1'b0;
        Byte_Out   = '0;
        case (state)
            IDLE: begin
                if (!Empty && armed) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                Read_Ack  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                Byte_Valid = 1'b1;
                Byte_Last  = is_last;
                Byte_Out   = sel_byte;
                if (handshake && is_last) begin
                    state_nxt = Empty ? IDLE : FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_packet_serializer.sv
// tb/tb_packet_serializer.sv - scoreboard bench for packet_serializer, both byte orders side by side (SERIALIZER_CHECKSUM_EN aware)
module tb_packet_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] packet_in;
    logic        empty;
    logic        br;
    logic        br_level;
    logic        toggle;

    logic        ra1, bv1, bl1, ra0, bv0, bl0;
    logic [7:0]  bo1, bo0;
    logic [15:0] pc1, pc0;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ack_cnt  = 0;
    int          exp_pkts = 0;

    logic [31:0] upq[$];
    logic [8:0]  exq1[$];
    logic [8:0]  exq0[$];
    int          stamps[$];
    int          ack_stamps[$];

    packet_serializer #(.MSB_FIRST(1'b1)) dut_msb (
        .Clk_r(clk), .Rst_n(rst_n), .Packet_In(packet_in), .Empty(empty),
        .Read_Ack(ra1), .Byte_Out(bo1), .Byte_Valid(bv1), .Byte_Ready(br),
        .Byte_Last(bl1), .Pkt_Count(pc1)
    );

    packet_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
        .Clk_r(clk), .Rst_n(rst_n), .Packet_In(packet_in), .Empty(empty),
        .Read_Ack(ra0), .Byte_Out(bo0), .Byte_Valid(bv0), .Byte_Ready(br),
        .Byte_Last(bl0), .Pkt_Count(pc0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic expect_word(input logic [31:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 4; i++) begin
            exq1.push_back({(i == NB - 1), w[(3 - i) * 8 +: 8]});
            exq0.push_back({(i == NB - 1), w[i * 8 +: 8]});
            x = x ^ w[i * 8 +: 8];
        end
        if (NB == 5) begin
            exq1.push_back({1'b1, x});
            exq0.push_back({1'b1, x});
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        upq.push_back(w);
        expect_word(w);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exq1.size() != 0 || exq0.size() != 0 || upq.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check(n < 400, "drain_timeout", n, 400);
        repeat (3) @(posedge clk);
        #2;
    endtask

    // Upstream queue: pop the head on the edge that ends a Read_Ack cycle.
    initial begin
        logic pop_req;
        empty     = 1'b1;
        packet_in = 32'h0;
        forever begin
            @(negedge clk);
            pop_req = ra1 && rst_n;
            @(posedge clk);
            #1;
            if (pop_req && upq.size() > 0) void'(upq.pop_front());
            empty     = (upq.size() == 0);
            packet_in = (upq.size() > 0) ? upq[0] : 32'h0;
        end
    end

    // Downstream ready: steady level or toggling every cycle.
    initial begin
        br = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            br = toggle ? ~br : br_level;
        end
    end

    // Read_Ack pulse counting and width.
    initial begin
        logic ra_prev;
        ra_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ra1) begin
                ack_cnt++;
                ack_stamps.push_back(cyc);
                if (ra_prev) check(1'b0, "read_ack_width", 2, 1);
            end
            ra_prev = ra1;
        end
    end

    // MSB-first monitor: scoreboard pop on handshake, stall stability.
    initial begin
        logic [8:0] e1, h1;
        logic       held1;
        held1 = 1'b0;
        h1    = '0;
        forever begin
            @(negedge clk);
            if (held1 && rst_n)
                check(bv1 && bo1 == h1[7:0] && bl1 == h1[8], "msb_stall_hold", {bv1, bl1, bo1}, {1'b1, h1});
            if (rst_n && !bv1 && bl1) check(1'b0, "msb_last_without_valid", bl1, 0);
            if (rst_n && bv1 && br) begin
                stamps.push_back(cyc);
                if (exq1.size() == 0) check(1'b0, "msb_extra_byte", bo1, 0);
                else begin
                    e1 = exq1.pop_front();
                    check(bo1 == e1[7:0], "msb_byte", bo1, e1[7:0]);
                    check(bl1 == e1[8], "msb_last", bl1, e1[8]);
                end
            end
            held1 = rst_n && bv1 && !br;
            h1    = {bl1, bo1};
        end
    end

    // LSB-first monitor.
    initial begin
        logic [8:0] e0, h0;
        logic       held0;
        held0 = 1'b0;
        h0    = '0;
        forever begin
            @(negedge clk);
            if (held0 && rst_n)
                check(bv0 && bo0 == h0[7:0] && bl0 == h0[8], "lsb_stall_hold", {bv0, bl0, bo0}, {1'b1, h0});
            if (rst_n && bv0 && br) begin
                if (exq0.size() == 0) check(1'b0, "lsb_extra_byte", bo0, 0);
                else begin
                    e0 = exq0.pop_front();
                    check(bo0 == e0[7:0], "lsb_byte", bo0, e0[7:0]);
                    check(bl0 == e0[8], "lsb_last", bl0, e0[8]);
                end
            end
            held0 = rst_n && bv0 && !br;
            h0    = {bl0, bo0};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, h0, n;
        rst_n    = 1'b0;
        br_level = 1'b1;
        toggle   = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check(ra1 == 0 && ra0 == 0, "reset_read_ack", {ra1, ra0}, 0);
        check(bv1 == 0 && bv0 == 0, "reset_valid", {bv1, bv0}, 0);
        check(bl1 == 0 && bl0 == 0, "reset_last", {bl1, bl0}, 0);
        check(bo1 == 0 && bo0 == 0, "reset_byte", {bo1, bo0}, 0);
        check(pc1 == 0 && pc0 == 0, "reset_count", {pc1, pc0}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle with empty queue.
        repeat (10) begin
            @(negedge clk);
            check(bv1 == 0 && bv0 == 0, "idle_no_valid", {bv1, bv0}, 0);
        end
        check(ack_cnt == 0, "idle_no_read_ack", ack_cnt, 0);
        check(pc1 == 0, "idle_count", pc1, 0);

        // Single word, ready held high.
        stamps.delete();
        ack_stamps.delete();
        a0 = ack_cnt;
        push_word(32'hA1B2C3D4);
        exp_pkts++;
        wait_drain();
        check(ack_cnt - a0 == 1, "single_ack_pulses", ack_cnt - a0, 1);
        check(stamps.size() == NB, "single_byte_count", stamps.size(), NB);
        for (int i = 1; i < stamps.size(); i++)
            check(stamps[i] - stamps[i - 1] == 1, "single_consecutive", stamps[i] - stamps[i - 1], 1);
        if (stamps.size() > 0 && ack_stamps.size() > 0)
            check(stamps[0] - ack_stamps[0] == 1, "fetch_to_first_valid", stamps[0] - ack_stamps[0], 1);
        check(pc1 == 16'(exp_pkts) && pc0 == 16'(exp_pkts), "single_count", pc1, exp_pkts);

        // Same word, ready toggling.
        toggle = 1'b1;
        push_word(32'hA1B2C3D4);
        exp_pkts++;
        wait_drain();
        toggle   = 1'b0;
        br_level = 1'b1;
        check(pc1 == 16'(exp_pkts) && pc0 == 16'(exp_pkts), "toggle_count", pc1, exp_pkts);

        // Three back-to-back words.
        stamps.delete();
        a0 = ack_cnt;
        push_word(32'h00000005);
        push_word(32'h00000006);
        push_word(32'h00000007);
        exp_pkts += 3;
        wait_drain();
        check(ack_cnt - a0 == 3, "b2b_ack_pulses", ack_cnt - a0, 3);
        check(stamps.size() == 3 * NB, "b2b_byte_count", stamps.size(), 3 * NB);
        for (int i = 1; i < stamps.size(); i++)
            check(stamps[i] - stamps[i - 1] == ((i % NB == 0) ? 2 : 1), "b2b_spacing",
                  stamps[i] - stamps[i - 1], (i % NB == 0) ? 2 : 1);
        check(pc1 == 16'(exp_pkts) && pc0 == 16'(exp_pkts), "b2b_count", pc1, exp_pkts);
        check(empty == 1'b1, "b2b_queue_empty", empty, 1);

        // Checksum-sensitive word.
        push_word(32'h01020304);
        exp_pkts++;
        wait_drain();
        check(pc1 == 16'(exp_pkts), "xor_word_count", pc1, exp_pkts);

        // Reset in the middle of a packet.
        h0 = stamps.size();
        push_word(32'h11223344);
        upq.push_back(32'h55667788);
        n = 0;
        while (stamps.size() < h0 + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check(n < 100, "abort_wait_timeout", n, 100);
        #2;
        rst_n = 1'b0;
        #1;
        check(bv1 == 0 && bv0 == 0, "abort_async_valid", {bv1, bv0}, 0);
        check(pc1 == 0 && pc0 == 0, "abort_count_cleared", {pc1, pc0}, 0);
        exq1.delete();
        exq0.delete();
        exp_pkts = 0;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expect_word(32'h55667788);
        @(posedge clk);
        @(negedge clk);
        check(ra1 == 0, "no_fetch_first_edge", ra1, 0);
        exp_pkts++;
        wait_drain();
        check(pc1 == 16'(exp_pkts) && pc0 == 16'(exp_pkts), "after_abort_count", pc1, exp_pkts);
        check(empty == 1'b1, "after_abort_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 sends bits [31:24] first, 0 sends bits [7:0] first.
REQ-002 SHALL have ports as below, with one clock; reset is asynchronous and active-low (Clk_r, Rst_n).
REQ-003 Clk_r  in  1  rising-edge clock.
REQ-004 Rst_n  in  1  asynchronous active-low reset.
REQ-005 Packet_In  in  32  head word of the upstream packet queue; valid whenever Empty=0.
REQ-006 Empty  in  1  upstream queue empty.
REQ-007 Read_Ack  out  1  one-cycle pop strobe to the upstream queue.
REQ-008 Byte_Out  out  8  current byte.
REQ-009 Byte_Valid  out  1  Byte_Out holds a valid byte.
REQ-010 Byte_Ready  in  1  downstream accepts the byte.
REQ-011 Byte_Last  out  1  current byte is the final byte of the packet.
REQ-012 Pkt_Count  out  16  number of fully sent packets; wraps from 0xFFFF to 0.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH and SEND, all registered (Moore outputs).
REQ-014 IDLE: Empty=0 sampled at a clock edge -> FETCH; otherwise stay in IDLE.
REQ-015 FETCH: Read_Ack=1 for exactly one cycle; at that edge, capture Packet_In into a 32-bit hold register, clear the byte index, and go to SEND.
REQ-016 Read_Ack SHALL be 0 in every state other than FETCH; one FETCH pops exactly one word.
REQ-017 SEND: Byte_Valid=1; Byte_Out = byte[index] in MSB_FIRST order; Byte_Out, Byte_Valid and Byte_Last SHALL hold stable while Byte_Ready=0.
REQ-018 A handshake is Byte_Valid&Byte_Ready at a rising edge; a handshake on a non-final byte increments the index.
REQ-019 A handshake on the final byte (index 3; index 4 with checksum) increments Pkt_Count. The next state is FETCH if Empty=0, else IDLE, so back-to-back packets have a one-cycle bubble.
REQ-020 Byte_Last SHALL be 1 only while SEND presents the final byte.
REQ-021 Latency: Empty falls before edge N -> Read_Ack high in cycle N..N+1 -> first Byte_Valid in cycle N+1..N+2.
REQ-022 Empty is ignored in FETCH and SEND; Packet_In changes after capture do not affect bytes in flight.
REQ-023 Byte_Ready while Byte_Valid=0 has no effect.

Reset
REQ-024 With Rst_n=0: state=IDLE, Read_Ack=0, Byte_Valid=0, Byte_Last=0, Byte_Out=0, hold register=0, index=0, Pkt_Count=0, checksum=0.
REQ-025 Reset asserted mid-packet SHALL abort that packet immediately; its remaining bytes are discarded and it is not re-fetched or counted.
REQ-026 After Rst_n deasserts, the first FETCH occurs no earlier than the second rising edge.

Configuration
REQ-027 Macro SERIALIZER_CHECKSUM_EN:
- Defined: a fifth byte equal to the XOR of the four data bytes follows the data bytes; Byte_Last is on the fifth byte only.
- Undefined: packets are exactly four bytes, with no checksum logic or register.

Structure
REQ-028 Shared package pkt_pkg SHALL hold the FSM state enum, PKT_W=32, BYTE_W=8, BYTES_PER_PKT=4, and CNT_W=16.
REQ-029 SHALL contain one sub-module, byte_sel: combinational selection of a byte from the word, index and MSB_FIRST (plus the XOR byte when enabled).

Verification
REQ-030 Reset, Empty=1 for 10 cycles -> Read_Ack never asserts, Byte_Valid=0, Pkt_Count=0.
REQ-031 One word 0xA1B2C3D4, Byte_Ready=1, MSB_FIRST=1 -> one Read_Ack pulse; bytes A1,B2,C3,D4 on consecutive cycles; Byte_Last on D4; Pkt_Count=1.
REQ-032 Same word with MSB_FIRST=0 and Byte_Ready toggling 1/0 -> bytes D4,C3,B2,A1; outputs held stable during Ready=0 cycles.
REQ-033 Queue preloaded with 5,6,7 and Byte_Ready=1 -> three Read_Ack pulses, 12 bytes in order, one bubble cycle between packets, Pkt_Count=3, Empty=1 at end.
REQ-034 SERIALIZER_CHECKSUM_EN defined, word 0x01020304 -> bytes 01,02,03,04,04 (XOR=0x04); Byte_Last on the fifth byte only.
REQ-035 Rst_n pulsed low after the second byte of 0x11223344 -> Byte_Valid drops asynchronously; Pkt_Count=0; the next queued word is sent intact from byte 0.
